// File: rtl/sys_ram_pkg.sv
// sys_ram_pkg: shared definitions for the sys_ram slice.
//   - bus widths and the NOP instruction returned on fetch misses
//   - RISC-V load/store funct3 codes
//   - machine timer register offsets and the timer register selector
//   - load_extend(): lane extraction and sign/zero extension for loads
package sys_ram_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;

  localparam logic [DATA_WIDTH-1:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  localparam logic [15:0] MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] MTIME_HI    = 16'hBFFC;

  typedef enum logic [1:0] {
    TSEL_CMP_LO,
    TSEL_CMP_HI,
    TSEL_MTIME_LO,
    TSEL_MTIME_HI
  } timer_sel_e;

  // b/bu pick the byte at lane; h/hu pick the half at lane[1]; w passes through.
  function automatic logic [DATA_WIDTH-1:0] load_extend(
    input logic [DATA_WIDTH-1:0] word,
    input logic [1:0]            lane,
    input logic [2:0]            funct3
  );
    logic [7:0]            b;
    logic [15:0]           h;
    logic [DATA_WIDTH-1:0] res;
    b = word[8*lane +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    res = {{24{b[7]}}, b};
      F3_H:    res = {{16{h[15]}}, h};
      F3_W:    res = word;
      F3_BU:   res = {24'h0, b};
      F3_HU:   res = {16'h0, h};
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sys_ram_if.sv
// sys_ram_if: core-to-memory signal bundle.
//   Data port : ram_request_i, ram_we_i, ram_op_i, ram_addr_i, ram_wdata_i -> ram_rdata_o
//   Fetch port: inst_ce_i, inst_addr_i -> inst_o
//   master = core side, slave = sys_ram side.
interface sys_ram_if;
  import sys_ram_pkg::*;

  logic                  ram_request_i;
  logic                  ram_we_i;
  logic [3:0]            ram_op_i;
  logic [ADDR_WIDTH-1:0] ram_addr_i;
  logic [DATA_WIDTH-1:0] ram_wdata_i;
  logic [DATA_WIDTH-1:0] ram_rdata_o;
  logic                  inst_ce_i;
  logic [ADDR_WIDTH-1:0] inst_addr_i;
  logic [DATA_WIDTH-1:0] inst_o;

  modport master (
    output ram_request_i, ram_we_i, ram_op_i, ram_addr_i, ram_wdata_i,
    output inst_ce_i, inst_addr_i,
    input  ram_rdata_o, inst_o
  );

  modport slave (
    input  ram_request_i, ram_we_i, ram_op_i, ram_addr_i, ram_wdata_i,
    input  inst_ce_i, inst_addr_i,
    output ram_rdata_o, inst_o
  );

endinterface

// File: rtl/sys_timer.sv
// sys_timer: machine timer (mtime / mtimecmp) with a word read/write port.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   we_i         : word write strobe for the register chosen by sel_i
//   sel_i        : register select (mtimecmp lo/hi, mtime lo/hi)
//   wdata_i      : write data
//   rdata_o      : combinational read of the selected register
//   irq_o        : registered (mtime >= mtimecmp)
module sys_timer
  import sys_ram_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  timer_sel_e            sel_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  irq_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] prescale;
  logic [63:0]   mtime;
  logic [63:0]   mtimecmp;
  logic          tick;

  assign tick = (prescale == PW'(TICK_DIV - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prescale <= '0;
      mtime    <= '0;
      mtimecmp <= '1;
      irq_o    <= 1'b0;
    end else begin
      prescale <= tick ? '0 : prescale + 1'b1;
      irq_o    <= (mtime >= mtimecmp);
      // A software write to either mtime half wins over the tick; no carry between halves.
      if (we_i && sel_i == TSEL_MTIME_LO)
        mtime[31:0] <= wdata_i;
      else if (we_i && sel_i == TSEL_MTIME_HI)
        mtime[63:32] <= wdata_i;
      else if (tick)
        mtime <= mtime + 64'd1;
      if (we_i && sel_i == TSEL_CMP_LO)
        mtimecmp[31:0] <= wdata_i;
      if (we_i && sel_i == TSEL_CMP_HI)
        mtimecmp[63:32] <= wdata_i;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (sel_i)
      TSEL_CMP_LO:   rdata_o = mtimecmp[31:0];
      TSEL_CMP_HI:   rdata_o = mtimecmp[63:32];
      TSEL_MTIME_LO: rdata_o = mtime[31:0];
      TSEL_MTIME_HI: rdata_o = mtime[63:32];
      default:       rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/sys_ram.sv
// sys_ram: unified word-addressed RAM with a load/store data port, a read-only
// fetch port, and a memory-mapped machine timer.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : sys_ram_if.slave (data port ram_*, fetch port inst_*)
//   timer_irq_o  : machine timer interrupt, level
// Loads and fetches are combinational; stores commit on the rising clock edge,
// so a read of a word being written returns its old value that cycle.
module sys_ram
  import sys_ram_pkg::*;
#(
  parameter int unsigned DEPTH      = 4096,
  parameter string       INIT_FILE  = "",
  parameter logic [31:0] TIMER_BASE = 32'h0200_0000,
  parameter int unsigned TICK_DIV   = 1
) (
  input  logic     clk_i,
  input  logic     rst_i,
  sys_ram_if.slave bus,
  output logic     timer_irq_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  d_ram_hit;
  logic [AW-1:0]         d_idx;
  logic                  t_hit;
  timer_sel_e            t_sel;
  logic [DATA_WIDTH-1:0] t_rdata;
  logic                  t_we;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wd;
  logic                  mem_we;
  logic                  i_hit;
  logic                  unused_bits;

  assign d_ram_hit = (bus.ram_addr_i[31:2] < 30'(DEPTH));
  assign d_idx     = bus.ram_addr_i[AW+1:2];
  assign i_hit     = (bus.inst_addr_i[31:2] < 30'(DEPTH));
  assign unused_bits = ^{bus.inst_addr_i[1:0], bus.ram_op_i[3]};

  // Timer registers decode on the word offset; byte lanes are handled like RAM.
  always_comb begin
    t_hit = 1'b0;
    t_sel = TSEL_CMP_LO;
    if (bus.ram_addr_i[31:16] == TIMER_BASE[31:16]) begin
      t_hit = 1'b1;
      case ({bus.ram_addr_i[15:2], 2'b00})
        MTIMECMP_LO: t_sel = TSEL_CMP_LO;
        MTIMECMP_HI: t_sel = TSEL_CMP_HI;
        MTIME_LO:    t_sel = TSEL_MTIME_LO;
        MTIME_HI:    t_sel = TSEL_MTIME_HI;
        default:     t_hit = 1'b0;
      endcase
    end
  end

  // RAM takes priority should the timer window ever overlap it.
  assign t_we = bus.ram_request_i && bus.ram_we_i && !d_ram_hit && t_hit &&
                (bus.ram_op_i[2:0] == F3_W);

  sys_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (t_we),
    .sel_i   (t_sel),
    .wdata_i (bus.ram_wdata_i),
    .rdata_o (t_rdata),
    .irq_o   (timer_irq_o)
  );

  // Load path.
  always_comb begin
    rd_word = '0;
    if (d_ram_hit)
      rd_word = mem[d_idx];
    else if (t_hit)
      rd_word = t_rdata;
    bus.ram_rdata_o = '0;
    if (bus.ram_request_i && !rst_i)
      bus.ram_rdata_o = load_extend(rd_word, bus.ram_addr_i[1:0], bus.ram_op_i[2:0]);
  end

  // Store lane enables with the source byte/half replicated across lanes.
  always_comb begin
    be = '0;
    wd = '0;
    case (bus.ram_op_i[2:0])
      F3_B: begin
        be = 4'b0001 << bus.ram_addr_i[1:0];
        wd = {4{bus.ram_wdata_i[7:0]}};
      end
      F3_H: begin
        be = bus.ram_addr_i[1] ? 4'b1100 : 4'b0011;
        wd = {2{bus.ram_wdata_i[15:0]}};
      end
      F3_W: begin
        be = '1;
        wd = bus.ram_wdata_i;
      end
      default: begin
        be = '0;
        wd = '0;
      end
    endcase
  end

  // The array has no reset; gating with rst_i drops a store caught by reset.
  assign mem_we = bus.ram_request_i && bus.ram_we_i && d_ram_hit && !rst_i;

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[d_idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  // Fetch path.
  always_comb begin
    bus.inst_o = INST_NOP;
    if (!rst_i && bus.inst_ce_i && i_hit)
      bus.inst_o = mem[bus.inst_addr_i[AW+1:2]];
  end

endmodule

// File: tb/tb_sys_ram.sv
module tb_sys_ram;
  import sys_ram_pkg::*;

  localparam int unsigned DEPTH    = 1024;
  localparam logic [31:0] TBASE    = 32'h0200_0000;
  localparam int unsigned TICK_DIV = 1;
  localparam logic [31:0] RAM_END  = DEPTH * 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic irq;

  sys_ram_if bus();

  sys_ram #(
    .DEPTH      (DEPTH),
    .INIT_FILE  (""),
    .TIMER_BASE (TBASE),
    .TICK_DIV   (TICK_DIV)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .timer_irq_o (irq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end
  endfunction

  // ---------------- reference model ----------------
  logic [7:0]      mb [DEPTH*4];
  longint unsigned m_mt;
  longint unsigned m_cmp;
  int unsigned     m_pre;
  logic            m_irq;

  function automatic void model_reset();
    m_mt  = 0;
    m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
    m_pre = 0;
    m_irq = 1'b0;
  endfunction

  function automatic bit is_ram(input logic [31:0] a);
    return a < RAM_END;
  endfunction

  // -1: no timer register; 0 cmp lo, 1 cmp hi, 2 mtime lo, 3 mtime hi
  function automatic int tsel(input logic [31:0] a);
    if ((a >> 16) != (TBASE >> 16)) return -1;
    case (a[15:0] & 16'hFFFC)
      16'h4000: return 0;
      16'h4004: return 1;
      16'hBFF8: return 2;
      16'hBFFC: return 3;
      default:  return -1;
    endcase
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] a);
    logic [31:0] b;
    if (is_ram(a)) begin
      b = a & ~32'd3;
      return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
    end
    case (tsel(a))
      0:       return m_cmp[31:0];
      1:       return m_cmp[63:32];
      2:       return m_mt[31:0];
      3:       return m_mt[63:32];
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] w;
    logic [7:0]  bv;
    logic [15:0] hv;
    w  = m_word(a);
    bv = 8'(w >> (8 * a[1:0]));
    hv = 16'(w >> (16 * a[1]));
    case (f3)
      3'd0:    return 32'(signed'(bv));
      3'd1:    return 32'(signed'(hv));
      3'd2:    return w;
      3'd4:    return 32'(bv);
      3'd5:    return 32'(hv);
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_clock(input logic req, input logic we, input logic [31:0] a,
                                      input logic [2:0] f3, input logic [31:0] d);
    logic        nxt_irq;
    bit          tick;
    int          t;
    logic [31:0] b;
    nxt_irq = (m_mt >= m_cmp);
    tick    = (m_pre == TICK_DIV - 1);
    m_pre   = tick ? 0 : m_pre + 1;
    t = -1;
    if (req && we) begin
      if (is_ram(a)) begin
        case (f3)
          3'd0: mb[a] = d[7:0];
          3'd1: begin b = a & ~32'd1; mb[b] = d[7:0]; mb[b+1] = d[15:8]; end
          3'd2: begin
            b = a & ~32'd3;
            mb[b] = d[7:0]; mb[b+1] = d[15:8]; mb[b+2] = d[23:16]; mb[b+3] = d[31:24];
          end
          default: ;
        endcase
      end else if (f3 == 3'd2) begin
        t = tsel(a);
      end
    end
    if (t == 2)      m_mt = {m_mt[63:32], d};
    else if (t == 3) m_mt = {d, m_mt[31:0]};
    else if (tick)   m_mt = m_mt + 1;
    if (t == 0) m_cmp = {m_cmp[63:32], d};
    if (t == 1) m_cmp = {d, m_cmp[31:0]};
    m_irq = nxt_irq;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        chk_rd;
    logic [31:0] rd;
    logic [31:0] inst;
    logic        irq;
    string       tag;
  } exp_t;

  exp_t  q[$];
  string cur_tag = "init";
  logic  ovr_rd_en = 1'b0;
  logic  [31:0] ovr_rd = '0;
  logic  ovr_inst_en = 1'b0;
  logic  [31:0] ovr_inst = '0;

  task automatic drive(input logic req, input logic we, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic ce, input logic [31:0] ia);
    exp_t e;
    bus.ram_request_i = req;
    bus.ram_we_i      = we;
    bus.ram_op_i      = op;
    bus.ram_addr_i    = a;
    bus.ram_wdata_i   = d;
    bus.inst_ce_i     = ce;
    bus.inst_addr_i   = ia;
    e.chk_rd = !(req && we);
    e.rd     = (req && !we) ? m_load(a, op[2:0]) : 32'h0;
    e.inst   = (ce && is_ram(ia)) ? m_word(ia) : INST_NOP;
    e.irq    = m_irq;
    e.tag    = cur_tag;
    if (ovr_rd_en)   e.rd   = ovr_rd;
    if (ovr_inst_en) e.inst = ovr_inst;
    ovr_rd_en   = 1'b0;
    ovr_inst_en = 1'b0;
    q.push_back(e);
    model_clock(req, we, a, op[2:0], d);
  endtask

  task automatic cyc(input logic req, input logic we, input logic [3:0] op,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic ce, input logic [31:0] ia);
    @(negedge clk);
    drive(req, we, op, a, d, ce, ia);
  endtask

  task automatic st(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    cyc(1'b1, 1'b1, {1'b0, f3}, a, d, 1'b0, 32'h0);
  endtask

  task automatic ld(input logic [31:0] a, input logic [2:0] f3);
    cyc(1'b1, 1'b0, {1'b0, f3}, a, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic ldc(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] c);
    ovr_rd_en = 1'b1;
    ovr_rd    = c;
    ld(a, f3);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Monitor: compares the DUT outputs presented for each issued cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk_rd) check({e.tag, "/rdata"}, bus.ram_rdata_o, e.rd);
        check({e.tag, "/inst"}, bus.inst_o, e.inst);
        check({e.tag, "/irq"}, {31'h0, irq}, {31'h0, e.irq});
      end
    end
  end

  // ---------------- random stimulus helpers ----------------
  function automatic logic [31:0] rnd_addr();
    logic [31:0] off;
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return 32'($urandom_range(0, 255));
      4:          return RAM_END - 32'd16 + 32'($urandom_range(0, 15));
      5:          return RAM_END + 32'($urandom_range(0, 15));
      6, 7: begin
        case ($urandom_range(0, 3))
          0:       off = 32'h4000;
          1:       off = 32'h4004;
          2:       off = 32'hBFF8;
          default: off = 32'hBFFC;
        endcase
        return TBASE + off + 32'($urandom_range(0, 3));
      end
      8:       return TBASE + 32'h1000 + 32'($urandom_range(0, 15));
      default: return 32'h8000_0000 + 32'($urandom_range(0, 255));
    endcase
  endfunction

  function automatic logic [31:0] rnd_fetch();
    case ($urandom_range(0, 3))
      0, 1:    return 32'($urandom_range(0, 255));
      2:       return RAM_END - 32'd16 + 32'($urandom_range(0, 15));
      default: return RAM_END + 32'($urandom_range(0, 63));
    endcase
  endfunction

  function automatic logic [2:0] rnd_load_f3();
    case ($urandom_range(0, 4))
      0:       return 3'd0;
      1:       return 3'd1;
      2:       return 3'd2;
      3:       return 3'd4;
      default: return 3'd5;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    logic [2:0]  f3;
    logic        ce;
    int unsigned k;

    bus.ram_request_i = 1'b1;
    bus.ram_we_i      = 1'b0;
    bus.ram_op_i      = 4'h2;
    bus.ram_addr_i    = 32'h0;
    bus.ram_wdata_i   = 32'h0;
    bus.inst_ce_i     = 1'b1;
    bus.inst_addr_i   = 32'h0;
    model_reset();

    #1 rst = 1'b1;
    #1;
    check("reset/rdata", bus.ram_rdata_o, 32'h0);
    check("reset/inst", bus.inst_o, INST_NOP);
    check("reset/irq", {31'h0, irq}, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);

    cur_tag = "prefill";
    for (int unsigned w = 0; w < 64; w++) st(w * 4, 3'd2, $urandom);
    for (int unsigned w = DEPTH - 4; w < DEPTH; w++) st(w * 4, 3'd2, $urandom);

    cur_tag = "lanes";
    st(32'h10, 3'd2, 32'h8899AABB);
    ldc(32'h13, 3'd0, 32'hFFFFFF88);
    ldc(32'h13, 3'd4, 32'h00000088);
    ldc(32'h12, 3'd1, 32'hFFFF8899);
    ldc(32'h12, 3'd5, 32'h00008899);
    ldc(32'h10, 3'd2, 32'h8899AABB);

    cur_tag = "merge";
    st(32'h10, 3'd2, 32'h11223344);
    st(32'h11, 3'd0, 32'hFFFFFF5A);
    ldc(32'h10, 3'd2, 32'h11225A44);
    st(32'h12, 3'd1, 32'h1234BEEF);
    ldc(32'h10, 3'd2, 32'hBEEF5A44);

    cur_tag = "fetch_rdw";
    st(32'h20, 3'd2, 32'h12345678);
    ovr_inst_en = 1'b1; ovr_inst = 32'h12345678;
    cyc(1'b1, 1'b1, 4'h2, 32'h20, 32'hCAFEF00D, 1'b1, 32'h20);
    ovr_inst_en = 1'b1; ovr_inst = 32'hCAFEF00D;
    cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h20);
    ovr_inst_en = 1'b1; ovr_inst = INST_NOP;
    cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h20);

    cur_tag = "mtime_wr";
    st(TBASE + 32'hBFFC, 3'd2, 32'h0);
    st(TBASE + 32'hBFF8, 3'd2, 32'hFFFFFFFF);
    ldc(TBASE + 32'hBFF8, 3'd2, 32'hFFFFFFFF);
    ldc(TBASE + 32'hBFFC, 3'd2, 32'h1);
    st(TBASE + 32'hBFFC, 3'd2, 32'h7);
    ldc(TBASE + 32'hBFF8, 3'd2, 32'h1);
    ldc(TBASE + 32'hBFFC, 3'd2, 32'h7);

    cur_tag = "pre_rst";
    st(TBASE + 32'h4000, 3'd2, 32'h0);
    st(TBASE + 32'h4004, 3'd2, 32'h0);
    idle();
    idle();

    // Reset arrives mid-cycle while a store is on the bus and stays high across the edge.
    @(negedge clk);
    bus.ram_request_i = 1'b1;
    bus.ram_we_i      = 1'b1;
    bus.ram_op_i      = 4'h2;
    bus.ram_addr_i    = 32'h40;
    bus.ram_wdata_i   = ~m_word(32'h40);
    bus.inst_ce_i     = 1'b1;
    bus.inst_addr_i   = 32'h40;
    check("pre_rst/irq", {31'h0, irq}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst/rdata", bus.ram_rdata_o, 32'h0);
    check("mid_rst/inst", bus.inst_o, INST_NOP);
    check("mid_rst/irq", {31'h0, irq}, 32'h0);
    @(posedge clk);
    #1 check("rst_edge/irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cur_tag = "post_rst";
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    ld(32'h40, 3'd2);

    cur_tag = "irq";
    st(TBASE + 32'h4004, 3'd2, 32'h0);
    st(TBASE + 32'h4000, 3'd2, 32'h5);
    repeat (6) idle();
    st(TBASE + 32'h4000, 3'd2, 32'hFFFFFFFF);
    repeat (3) idle();

    cur_tag = "random";
    for (int n = 0; n < 1500; n++) begin
      a  = rnd_addr();
      ce = ($urandom_range(0, 3) != 0);
      k  = $urandom_range(0, 9);
      if (k < 5) begin
        f3 = rnd_load_f3();
        cyc(1'b1, 1'b0, {1'($urandom_range(0, 1)), f3}, a, $urandom, ce, rnd_fetch());
      end else if (k < 9) begin
        f3 = 3'($urandom_range(0, 2));
        cyc(1'b1, 1'b1, {1'($urandom_range(0, 1)), f3}, a, $urandom, ce, rnd_fetch());
      end else begin
        cyc(1'b0, 1'($urandom_range(0, 1)), 4'h2, a, $urandom, ce, rnd_fetch());
      end
    end

    cur_tag = "decode_miss";
    st(RAM_END, 3'd2, 32'h5555AAAA);
    ldc(RAM_END, 3'd2, 32'h0);
    ldc(TBASE + 32'h1000, 3'd2, 32'h0);
    ldc(32'h8000_0010, 3'd2, 32'h0);
    idle();

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #5;
    check("drain/pending", 32'(q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
